// File: rtl/map_move_scheduler.sv
// Move pulse sequencer for the map generator: periodic move_map, alternating
// obstacle/objective requests with an acknowledge window and retry on miss.
module map_move_scheduler #(
    parameter int unsigned MOVE_PERIOD = 500,
    parameter int unsigned GEN_EVERY   = 4,
    parameter int unsigned ACK_WAIT    = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic [1:0]       speed_level_i,
    input  logic             obstacle_generated_i,
    input  logic             objective_generated_i,
    output logic             move_map_o,
    output logic             sel_obstacle_o,
    output logic             sel_objective_o,
    output logic [CNT_W-1:0] move_count_o,
    output logic             gen_miss_o
);

    localparam int unsigned WAIT_W = (ACK_WAIT > 1) ? $clog2(ACK_WAIT + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  move_count_q, move_count_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              move_map_q, move_map_d;
    logic              sel_obs_q, sel_obs_d;
    logic              sel_obj_q, sel_obj_d;
    logic              gen_miss_q, gen_miss_d;
    logic              alt_q, alt_d;      // 0: next request is obstacle
    logic              retry_q, retry_d;

    logic [CNT_W-1:0]  scaled_c, min_period_c, period_c, count_inc_c;
    logic              last_c, gen_due_c, matched_c;

    // Effective period, clamped so the ack window always fits inside it
    always_comb begin
        scaled_c     = CNT_W'(MOVE_PERIOD) >> speed_level_i;
        min_period_c = CNT_W'(ACK_WAIT + 2);
        period_c     = (scaled_c < min_period_c) ? min_period_c : scaled_c;
        count_inc_c  = move_count_q + CNT_W'(1);
        last_c       = (period_cnt_q == (period_q - CNT_W'(1)));
        gen_due_c    = retry_q || ((count_inc_c % CNT_W'(GEN_EVERY)) == '0);
        matched_c    = (sel_obs_q && obstacle_generated_i) ||
                       (sel_obj_q && objective_generated_i);
    end

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q + CNT_W'(1);
        period_d     = period_q;
        move_count_d = move_count_q;
        wait_d       = wait_q;
        move_map_d   = 1'b0;
        sel_obs_d    = sel_obs_q;
        sel_obj_d    = sel_obj_q;
        gen_miss_d   = 1'b0;
        alt_d        = alt_q;
        retry_d      = retry_q;

        case (state_q)
            S_IDLE: begin
                period_cnt_d = '0;
                sel_obs_d    = 1'b0;
                sel_obj_d    = 1'b0;
                if (enable_i) begin
                    state_d  = S_RUN;
                    period_d = period_c;
                end
            end
            S_RUN: begin
                if (last_c) begin
                    move_map_d   = 1'b1;
                    period_cnt_d = '0;
                    period_d     = period_c;
                    move_count_d = count_inc_c;
                    if (gen_due_c) begin
                        sel_obs_d = ~alt_q;
                        sel_obj_d = alt_q;
                        wait_d    = WAIT_W'(1);
                        state_d   = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (matched_c) begin
                    sel_obs_d = 1'b0;
                    sel_obj_d = 1'b0;
                    alt_d     = ~alt_q;
                    retry_d   = 1'b0;
                    state_d   = S_RUN;
                end else if (wait_q == WAIT_W'(ACK_WAIT)) begin
                    gen_miss_d = 1'b1;
                    sel_obs_d  = 1'b0;
                    sel_obj_d  = 1'b0;
                    retry_d    = 1'b1;
                    state_d    = S_RUN;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Halting keeps count/alternation; an interrupted request becomes a retry
        if (!enable_i) begin
            state_d      = S_IDLE;
            period_cnt_d = '0;
            period_d     = period_q;
            move_count_d = move_count_q;
            move_map_d   = 1'b0;
            sel_obs_d    = 1'b0;
            sel_obj_d    = 1'b0;
            gen_miss_d   = 1'b0;
            alt_d        = alt_q;
            retry_d      = (state_q == S_ACK) ? 1'b1 : retry_q;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            period_cnt_q <= '0;
            period_q     <= '0;
            move_count_q <= '0;
            wait_q       <= '0;
            move_map_q   <= 1'b0;
            sel_obs_q    <= 1'b0;
            sel_obj_q    <= 1'b0;
            gen_miss_q   <= 1'b0;
            alt_q        <= 1'b0;
            retry_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            period_q     <= period_d;
            move_count_q <= move_count_d;
            wait_q       <= wait_d;
            move_map_q   <= move_map_d;
            sel_obs_q    <= sel_obs_d;
            sel_obj_q    <= sel_obj_d;
            gen_miss_q   <= gen_miss_d;
            alt_q        <= alt_d;
            retry_q      <= retry_d;
        end
    end

    assign move_map_o      = move_map_q;
    assign sel_obstacle_o  = sel_obs_q;
    assign sel_objective_o = sel_obj_q;
    assign move_count_o    = move_count_q;
    assign gen_miss_o      = gen_miss_q;

endmodule

// File: doc/map_move_scheduler.md
Name: map_move_scheduler

Overview:
- Sequencer for the delivery game's map generator.
- Produces the periodic move_map pulse and chooses which moves carry an obstacle or objective request.
- Holds sel_obstacle/sel_objective through an acknowledge window and retries unacknowledged requests.
- Sits between the game control FSM (enable, speed level) and generate_map (move/sel outputs, *_generated feedback).

Parameters:
MOVE_PERIOD, 500, base clock cycles between move_map pulses (1 kHz clock -> 0.5 s)
GEN_EVERY, 4, every GEN_EVERY-th move is a generation move
ACK_WAIT, 2, cycles after the move_map pulse during which sel stays asserted awaiting acknowledge
CNT_W, 16, width of period counter and move_count

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  game running; low halts scheduling
speed_level  input  2  period divider exponent
obstacle_generated  input  1  acknowledge from generate_map
objective_generated  input  1  acknowledge from generate_map
move_map  output  1  one-cycle move pulse
sel_obstacle  output  1  obstacle request, valid with move_map and the ACK window
sel_objective  output  1  objective request, valid with move_map and the ACK window
move_count  output  CNT_W  number of pulses issued, wraps
gen_miss  output  1  one-cycle pulse when the ACK window expires without acknowledge

Behaviour:
- One clock. Reset is synchronous and active-high.
- All outputs are registered.
- Reset clears every output, the counters and the state to 0/IDLE. Alternation restarts at obstacle and the retry flag clears.
- Reset has priority over all other inputs in every state, including mid-ACK.
- Effective period P = max(MOVE_PERIOD >> speed_level, ACK_WAIT+2).
  - P is sampled when the period counter reloads.
  - A change of speed_level takes effect from the next period.
- States:
  - IDLE: outputs low. enable=1 -> RUN, period counter loaded to 0.
  - RUN: counter increments each cycle. When it reaches P-1:
    - move_map=1 for one cycle and the counter reloads to 0.
    - move_count increments, wrapping 2^CNT_W-1 -> 0.
    - If the move is a generation move, the request is driven and the state goes to ACK; otherwise the state stays RUN.
  - ACK: sel stays held for up to ACK_WAIT cycles after the pulse. The period counter keeps running.
    - The matching *_generated seen -> sel drops the next cycle, then RUN. The alternation toggles and the retry flag clears.
    - Window expires -> gen_miss=1 for one cycle, sel drops, RUN, retry flag set. The type is not toggled.
    - A non-matching *_generated is ignored.
- Generation move: the move where (move_count+1) mod GEN_EVERY == 0, or any move while the retry flag is set.
- Request type alternates obstacle, objective, obstacle, ...
  - sel_obstacle and sel_objective are never both 1.
  - A generation move that falls due while a retry is pending issues the retried type only (no doubling).
- enable=0 in any state -> IDLE on the next edge, all outputs low.
  - An ACK interrupted by enable=0 raises no gen_miss.
  - The interrupted request is kept as a pending retry.
  - move_count, the alternation and the retry flag are kept.
- First pulse comes P cycles after the edge where IDLE->RUN. Later pulses are spaced exactly P cycles apart, rising edge to rising edge.

Test Plan:
- Setup: bench uses MOVE_PERIOD=10, GEN_EVERY=4, ACK_WAIT=2, and an ack model answering 1 cycle after move_map.
- Reset test: assert reset 3 cycles, then enable=0 -> all outputs 0, move_count=0.
- Enable=1, speed_level=0:
  - move_map every 10 cycles, first pulse 10 cycles after entering RUN.
  - move_count 1, 2, 3, ...
  - Moves 4/8/12/16 carry sel_obstacle/sel_objective/sel_obstacle/sel_objective; other moves have sel=0.
- Ack model silent on move 4:
  - gen_miss pulses 2 cycles after move 4.
  - Move 5 carries sel_obstacle, which is acknowledged.
  - Move 8 carries sel_objective.
- Period scaling:
  - speed_level=1 -> pulses 5 cycles apart from the following period.
  - speed_level=3 -> 10>>3=1, clamped to 4-cycle spacing.
- Drop enable one cycle after a generation pulse:
  - Outputs are 0 the next cycle and there is no gen_miss.
  - Re-enable -> the next pulse carries the same request type.
- Wrap and reset:
  - With CNT_W=4, 16 pulses -> move_count wraps to 0.
  - Reset asserted in ACK -> everything 0 the next cycle, and the next generation move after re-enable is obstacle.
